bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus masters sharing the single multiplexed system bus (range 2..8).
REQ-002 SHALL have parameter GRANT_TIMEOUT, default 16, the maximum number of cycles a granted master may take to begin a transaction; 0 disables the timeout.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL provide clk_i  input  1  system clock; all logic rising-edge.
REQ-005 SHALL provide rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL provide request_i  input  NUM_MASTERS  per-master bus request, level.
REQ-007 SHALL provide bus_beginTransaction_i  input  1  begin strobe observed on the shared bus.
REQ-008 SHALL provide bus_endTransaction_i  input  1  end strobe observed on the shared bus, from master or slave.
REQ-009 SHALL provide bus_error_i  input  1  bus error observed on the shared bus.
REQ-010 SHALL provide grant_o  output  NUM_MASTERS  registered grant, one-hot or all-zero.
REQ-011 SHALL provide owner_o  output  clog2(NUM_MASTERS)  index of the granted master; 0 when grant_o is zero.
REQ-012 SHALL provide active_o  output  1  high while a granted transaction is in progress.
REQ-013 SHALL provide timeout_o  output  1  one-cycle pulse when a grant is revoked because of the timeout.

Function
REQ-014 SHALL implement the states IDLE, GRANTED, ACTIVE and RELEASE, all outputs registered.
REQ-015 In IDLE with any request_i bit set, the block SHALL select the first requesting index at or after (last_owner+1) mod NUM_MASTERS, assert grant_o for it on the next cycle and enter GRANTED; with no request it SHALL stay in IDLE with grant_o = 0.
REQ-016 The latency from a request sampled in IDLE to grant_o high SHALL be exactly 1 cycle.
REQ-017 In GRANTED, on bus_beginTransaction_i the block SHALL enter ACTIVE and set active_o on the next cycle.
REQ-018 In GRANTED, if bus_beginTransaction_i and bus_endTransaction_i are high together (single-cycle transfer), the block SHALL enter RELEASE directly.
REQ-019 In GRANTED, if bus_error_i is high or the owner's request_i bit is low, the block SHALL enter RELEASE (error takes priority over begin).
REQ-020 In GRANTED, if GRANT_TIMEOUT>0 and GRANT_TIMEOUT cycles elapse with grant_o high and no begin, the block SHALL enter RELEASE and pulse timeout_o for the first RELEASE cycle.
REQ-021 The timeout counter SHALL clear on every entry to GRANTED, be clog2(GRANT_TIMEOUT+1) bits wide and never wrap.
REQ-022 In ACTIVE, on bus_endTransaction_i or bus_error_i (same action if both are high), the block SHALL enter RELEASE; bus_beginTransaction_i and request_i changes SHALL be ignored.
REQ-023 ACTIVE SHALL have no timeout; the grant is held until an end strobe or an error occurs.
REQ-024 RELEASE SHALL last exactly 1 cycle with grant_o = 0, active_o = 0 and owner_o = 0; it SHALL record last_owner = the released index and return to IDLE.
REQ-025 The minimum gap between an end strobe and the next grant SHALL therefore be 2 cycles: RELEASE, then IDLE arbitration, then grant.
REQ-026 grant_o SHALL never have more than one bit set, and owner_o SHALL equal the index of that bit.

Reset
REQ-027 When rst_ni is low, at any time including mid-transaction, the block SHALL immediately force the state to IDLE, grant_o = 0, owner_o = 0, active_o = 0, timeout_o = 0, the counter to 0 and last_owner = NUM_MASTERS-1, so that master 0 wins first.
REQ-028 The first arbitration SHALL occur on the first rising clk_i edge after rst_ni deasserts.

Verification
REQ-029 request_i=4'b1111 held, each grant completed by begin and then end 3 cycles later -> grant order 0,1,2,3,0 with exactly one zero-grant cycle plus one IDLE cycle between grants.
REQ-030 request_i=4'b0100, no begin, GRANT_TIMEOUT=16 -> grant_o=4'b0100 for exactly 16 cycles, then timeout_o=1 for 1 cycle with grant_o=0, then a re-grant of master 2.
REQ-031 Master 1 granted, then begin and end in the same cycle -> next cycle is RELEASE with grant_o=0 and active_o never set.
REQ-032 Master 3 in ACTIVE, bus_error_i=1 together with bus_endTransaction_i=1 -> single RELEASE, last_owner=3, next grant goes to master 0 if it is requesting.
REQ-033 rst_ni pulsed low while ACTIVE with owner 2 -> all outputs 0 within the same cycle; after release with request_i=4'b0101 -> master 0 granted first.
REQ-034 Owner 1 drops request_i before begin -> RELEASE next cycle, timeout_o stays 0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a single multiplexed system bus.
//
// A master is granted for one bus transaction at a time. The grant is
// revoked when the transaction ends, on a bus error, when the owner drops
// its request before starting, or when the owner never starts within
// GRANT_TIMEOUT cycles. Every grant is followed by one RELEASE cycle and one
// IDLE arbitration cycle. Priority rotates, starting just after the last owner.
//
// Ports:
//   clk_i                  system clock, rising edge
//   rst_ni                 asynchronous active-low reset
//   request_i              per-master request level
//   bus_beginTransaction_i begin strobe seen on the shared bus
//   bus_endTransaction_i   end strobe seen on the shared bus
//   bus_error_i            error seen on the shared bus
//   grant_o                registered grant, one-hot or zero
//   owner_o                index of the granted master, 0 when no grant
//   active_o               high while the granted transaction is running
//   timeout_o              one-cycle pulse when a grant times out
module bus_arbiter_rr #(
  parameter int NUM_MASTERS   = 4,
  parameter int GRANT_TIMEOUT = 16,
  localparam int OWNER_W      = $clog2(NUM_MASTERS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_MASTERS-1:0] request_i,
  input  logic                   bus_beginTransaction_i,
  input  logic                   bus_endTransaction_i,
  input  logic                   bus_error_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [OWNER_W-1:0]     owner_o,
  output logic                   active_o,
  output logic                   timeout_o
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CNT_W = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    ACTIVE,
    RELEASE
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic                   active_q, active_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       waitCnt_q, waitCnt_d;
  logic [OWNER_W-1:0]     lastOwner_q, lastOwner_d;

  logic                   winnerFound;
  logic [OWNER_W-1:0]     winner;
  logic                   releaseNow;

  // Rotating search. It walks from the farthest candidate to the nearest one,
  // so the last hit is the first requester after lastOwner_q.
  always_comb begin
    winnerFound = 1'b0;
    winner      = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (request_i[OWNER_W'((int'(lastOwner_q) + k) % NUM_MASTERS)]) begin
        winnerFound = 1'b1;
        winner      = OWNER_W'((int'(lastOwner_q) + k) % NUM_MASTERS);
      end
    end
  end

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    active_d    = active_q;
    timeout_d   = 1'b0;
    waitCnt_d   = waitCnt_q;
    lastOwner_d = lastOwner_q;
    releaseNow  = 1'b0;

    case (state_q)
      IDLE: begin
        if (winnerFound) begin
          state_d   = GRANTED;
          grant_d   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
          owner_d   = winner;
          waitCnt_d = '0;
        end
      end

      GRANTED: begin
        // Error and a withdrawn request win over begin. The timeout fires
        // only in the cycle that completes GRANT_TIMEOUT cycles with no begin.
        if (bus_error_i || !request_i[owner_q]) begin
          releaseNow = 1'b1;
        end else if (bus_beginTransaction_i && bus_endTransaction_i) begin
          releaseNow = 1'b1;
        end else if (bus_beginTransaction_i) begin
          state_d  = ACTIVE;
          active_d = 1'b1;
        end else if (GRANT_TIMEOUT > 0 &&
                     waitCnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
          releaseNow = 1'b1;
          timeout_d  = 1'b1;
        end else if (waitCnt_q != {CNT_W{1'b1}}) begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end

      ACTIVE: begin
        if (bus_endTransaction_i || bus_error_i) begin
          releaseNow = 1'b1;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // lastOwner is captured on entry to RELEASE because owner_o is already
    // zero during that cycle. It is first used by the IDLE cycle that follows.
    if (releaseNow) begin
      state_d     = RELEASE;
      grant_d     = '0;
      owner_d     = '0;
      active_d    = 1'b0;
      lastOwner_d = owner_q;
    end
  end

  // State and output registers. After reset, lastOwner points at the top
  // index so that master 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      active_q    <= 1'b0;
      timeout_q   <= 1'b0;
      waitCnt_q   <= '0;
      lastOwner_q <= OWNER_W'(NUM_MASTERS - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      active_q    <= active_d;
      timeout_q   <= timeout_d;
      waitCnt_q   <= waitCnt_d;
      lastOwner_q <= lastOwner_d;
    end
  end

  assign grant_o   = grant_q;
  assign owner_o   = owner_q;
  assign active_o  = active_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr with 4 masters and a 16-cycle grant timeout.
// A transaction-level model of the arbiter predicts the outputs every cycle.
// Directed scenarios add literal expectations for grant order, gaps,
// timeout length, the single-cycle transfer, error handling and reset.
module tb_bus_arbiter_rr;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic         clock = 1'b0;
  logic         rstN;
  logic [N-1:0] request;
  logic         beginTx;
  logic         endTx;
  logic         busError;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         active;
  logic         timeout;

  int nChecks = 0;
  int nPass   = 0;
  bit cmpEn   = 1'b0;

  bus_arbiter_rr #(
    .NUM_MASTERS  (N),
    .GRANT_TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i                 (clock),
    .rst_ni                (rstN),
    .request_i             (request),
    .bus_beginTransaction_i(beginTx),
    .bus_endTransaction_i  (endTx),
    .bus_error_i           (busError),
    .grant_o               (grant),
    .owner_o               (owner),
    .active_o              (active),
    .timeout_o             (timeout)
  );

  always #5 clock = ~clock;

  // The model tracks the current owner (-1 when nobody holds the bus),
  // whether a transfer has started, how many cycles the grant has been
  // visible without a begin, and whether this is the post-release gap cycle.
  typedef struct {
    int owner;
    bit started;
    bit timedOut;
    bit inRelease;
    int waitCycles;
    int last;
  } modelT;

  modelT m;

  function automatic bit bitAt(logic [N-1:0] v, int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic modelT resetModel();
    modelT r;
    r.owner      = -1;
    r.started    = 1'b0;
    r.timedOut   = 1'b0;
    r.inRelease  = 1'b0;
    r.waitCycles = 0;
    r.last       = N - 1;
    return r;
  endfunction

  function automatic modelT nextModel(modelT s, logic [N-1:0] req, logic b,
                                      logic e, logic er);
    modelT n = s;
    bit rel = 1'b0;
    n.timedOut = 1'b0;
    if (s.inRelease) begin
      n.inRelease = 1'b0;
    end else if (s.owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int cand = (s.last + k) % N;
        if (n.owner < 0 && bitAt(req, cand)) begin
          n.owner      = cand;
          n.waitCycles = 0;
        end
      end
    end else if (!s.started) begin
      n.waitCycles = s.waitCycles + 1;
      if (er || !bitAt(req, s.owner)) rel = 1'b1;
      else if (b && e) rel = 1'b1;
      else if (b) n.started = 1'b1;
      else if (TIMEOUT > 0 && n.waitCycles == TIMEOUT) begin
        rel        = 1'b1;
        n.timedOut = 1'b1;
      end
    end else if (e || er) begin
      rel = 1'b1;
    end
    if (rel) begin
      n.last      = s.owner;
      n.owner     = -1;
      n.started   = 1'b0;
      n.inRelease = 1'b1;
    end
    return n;
  endfunction

  // Advance the model on the same edges as the DUT.
  always @(posedge clock or negedge rstN) begin
    if (!rstN) m <= resetModel();
    else       m <= nextModel(m, request, beginTx, endTx, busError);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs, then wait until the results are visible.
  task automatic applyStimulus(input logic [N-1:0] r, input logic b,
                               input logic e, input logic er);
    request  = r;
    beginTx  = b;
    endTx    = e;
    busError = er;
    @(negedge clock);
  endtask

  // Compare the DUT with the model every cycle, away from the active edge.
  always @(negedge clock) begin
    if (cmpEn) begin
      checkOutput("model_grant", int'(grant), (m.owner >= 0) ? (1 << m.owner) : 0);
      checkOutput("model_owner", int'(owner), (m.owner >= 0) ? m.owner : 0);
      checkOutput("model_active", int'(active), int'(m.started));
      checkOutput("model_timeout", int'(timeout), int'(m.timedOut));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expOrder [5] = '{1, 2, 4, 8, 1};
    int n;
    int hi;

    m        = resetModel();
    rstN     = 1'b0;
    request  = '0;
    beginTx  = 1'b0;
    endTx    = 1'b0;
    busError = 1'b0;
    repeat (2) @(negedge clock);
    cmpEn = 1'b1;
    checkOutput("reset_grant", int'(grant), 0);
    checkOutput("reset_owner", int'(owner), 0);
    checkOutput("reset_active", int'(active), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    request = 4'b1111;
    @(negedge clock);
    checkOutput("reset_hold_grant", int'(grant), 0);
    rstN = 1'b1;

    $display("[TB] round robin with all masters requesting");
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (grant == '0 && n < 20) begin
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
        n++;
      end
      if (g == 0) checkOutput("first_grant_latency", n, 1);
      else        checkOutput("rr_gap", n, 2);
      checkOutput("rr_order", int'(grant), expOrder[g]);
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
      checkOutput("rr_active", int'(active), 1);
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
      checkOutput("rr_release_grant", int'(grant), 0);
      checkOutput("rr_release_active", int'(active), 0);
    end

    $display("[TB] grant timeout on master 2");
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    hi = 0;
    while (grant == 4'b0100 && hi < 40) begin
      hi++;
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("to_grant_cycles", hi, 16);
    checkOutput("to_pulse", int'(timeout), 1);
    checkOutput("to_grant_zero", int'(grant), 0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("to_pulse_end", int'(timeout), 0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("to_regrant", int'(grant), 4'b0100);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] single-cycle transfer on master 1");
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("single_grant", int'(grant), 4'b0010);
    applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
    checkOutput("single_release_grant", int'(grant), 0);
    checkOutput("single_release_active", int'(active), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] error with end while master 3 is active");
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    checkOutput("err_grant", int'(grant), 4'b1000);
    checkOutput("err_owner", int'(owner), 3);
    applyStimulus(4'b1001, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("active_ignores_req", int'(active), 1);
    checkOutput("active_hold_grant", int'(grant), 4'b1000);
    applyStimulus(4'b1001, 1'b0, 1'b1, 1'b1);
    checkOutput("err_release_grant", int'(grant), 0);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    checkOutput("err_idle_grant", int'(grant), 0);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    checkOutput("err_next_master0", int'(grant), 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset while master 2 is active");
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_active", int'(active), 1);
    checkOutput("pre_reset_owner", int'(owner), 2);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_reset_grant", int'(grant), 0);
    checkOutput("async_reset_owner", int'(owner), 0);
    checkOutput("async_reset_active", int'(active), 0);
    checkOutput("async_reset_timeout", int'(timeout), 0);
    beginTx = 1'b0;
    @(negedge clock);
    rstN = 1'b1;
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_master0", int'(grant), 4'b0001);

    $display("[TB] owner drops its request before begin");
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b1);
    checkOutput("granted_error_release", int'(grant), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_grant", int'(grant), 4'b0010);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_release_grant", int'(grant), 0);
    checkOutput("drop_no_timeout", int'(timeout), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] begin in the last cycle before timeout");
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    repeat (15) applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("edge_still_granted", int'(grant), 4'b1000);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    checkOutput("edge_active", int'(active), 1);
    checkOutput("edge_no_timeout", int'(timeout), 0);
    applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] error beats begin in GRANTED");
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("prio_grant", int'(grant), 4'b0001);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
    checkOutput("prio_release_grant", int'(grant), 0);
    checkOutput("prio_no_active", int'(active), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
